// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe : RV32I instruction-decode stage with ID/EX pipeline register.
//
// Decodes the incoming instruction, builds the sign-extended immediate, picks
// the ALU operands and latches everything into the ID/EX register. A valid/
// ready handshake faces fetch (i_valid/o_ready) and execute (o_valid/
// i_ex_ready). A load whose result is needed by the very next instruction
// costs one bubble. i_flush kills both the instruction in ID and the register.
//
// Ports
//   clk, rst                 core clock, async active-high reset
//   i_valid / o_ready        fetch handshake (o_ready is combinational)
//   i_instruct, i_currentPC  instruction word and its PC
//   o_rs1, o_rs2             register-file read addresses (combinational)
//   i_regData1, i_regData2   register-file read data, same cycle
//   i_flush                  taken branch/jump: drop ID and ID/EX contents
//   i_ex_ready / o_valid     execute handshake
//   o_jal..o_RegWrite        registered control enables
//   o_Data_sel, o_ALUop      writeback select, ALU operation class
//   o_op1, o_op2, o_imm      registered operands and immediate
//   o_Rdata2, o_pc           store data and PC of the latched instruction
//   o_rd, o_func, o_func3    destination register and function fields
//   o_illegal                opcode outside the supported set
//   o_stall_cnt              saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int XLEN      = 32,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_instruct,
   input  logic [XLEN-1:0]  i_currentPC,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   input  logic [XLEN-1:0]  i_regData1,
   input  logic [XLEN-1:0]  i_regData2,
   input  logic             i_flush,
   input  logic             i_ex_ready,
   output logic             o_valid,
   output logic             o_jal,
   output logic             o_jalr,
   output logic             o_branch,
   output logic             o_MemRead,
   output logic             o_MemWrite,
   output logic             o_RegWrite,
   output logic [1:0]       o_Data_sel,
   output logic [2:0]       o_ALUop,
   output logic [XLEN-1:0]  o_op1,
   output logic [XLEN-1:0]  o_op2,
   output logic [XLEN-1:0]  o_imm,
   output logic [XLEN-1:0]  o_Rdata2,
   output logic [XLEN-1:0]  o_pc,
   output logic [4:0]       o_rd,
   output logic [3:0]       o_func,
   output logic [2:0]       o_func3,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic            op1_pc;   // op1 = PC instead of rs1 data
      logic            op2_imm;  // op2 = immediate instead of rs2 data
      logic [2:0]      alu;
      logic [1:0]      dsel;
      logic            rw;
      logic            jal;
      logic            jalr;
      logic            br;
      logic            mr;
      logic            mw;
      logic            ill;
      logic            use1;
      logic            use2;
      logic [XLEN-1:0] imm;
   } dec_t;

   dec_t            dec;
   logic [6:0]      opcode;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] op1_d, op2_d;
   logic            advance, hazard;

   assign opcode = i_instruct[6:0];
   assign o_rs1  = i_instruct[19:15];
   assign o_rs2  = i_instruct[24:20];

   assign imm_i = {{(XLEN-11){i_instruct[31]}}, i_instruct[30:20]};
   assign imm_s = {{(XLEN-11){i_instruct[31]}}, i_instruct[30:25], i_instruct[11:7]};
   assign imm_b = {{(XLEN-12){i_instruct[31]}}, i_instruct[7], i_instruct[30:25],
                   i_instruct[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){i_instruct[31]}}, i_instruct[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){i_instruct[31]}}, i_instruct[19:12], i_instruct[20],
                   i_instruct[30:21], 1'b0};

   always_comb begin
      dec = '0;
      case (opcode)
         OPC_LUI:    begin dec.imm = imm_u; dec.op2_imm = 1'b1; dec.alu = 3'b100;
                           dec.dsel = 2'b11; dec.rw = 1'b1; end
         OPC_AUIPC:  begin dec.imm = imm_u; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
                           dec.rw = 1'b1; end
         OPC_JAL:    begin dec.imm = imm_j; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
                           dec.dsel = 2'b10; dec.rw = 1'b1; dec.jal = 1'b1; end
         OPC_JALR:   begin dec.imm = imm_i; dec.op2_imm = 1'b1; dec.dsel = 2'b10;
                           dec.rw = 1'b1; dec.jalr = 1'b1; dec.use1 = 1'b1; end
         OPC_BRANCH: begin dec.imm = imm_b; dec.alu = 3'b001; dec.br = 1'b1;
                           dec.use1 = 1'b1; dec.use2 = 1'b1; end
         OPC_LOAD:   begin dec.imm = imm_i; dec.op2_imm = 1'b1; dec.dsel = 2'b01;
                           dec.rw = 1'b1; dec.mr = 1'b1; dec.use1 = 1'b1; end
         OPC_STORE:  begin dec.imm = imm_s; dec.op2_imm = 1'b1; dec.mw = 1'b1;
                           dec.use1 = 1'b1; dec.use2 = 1'b1; end
         OPC_OPIMM:  begin dec.imm = imm_i; dec.op2_imm = 1'b1; dec.alu = 3'b011;
                           dec.rw = 1'b1; dec.use1 = 1'b1; end
         OPC_OP:     begin dec.alu = 3'b010; dec.rw = 1'b1;
                           dec.use1 = 1'b1; dec.use2 = 1'b1; end
         default:    dec.ill = 1'b1;
      endcase
   end

   assign op1_d = dec.op1_pc  ? i_currentPC : i_regData1;
   assign op2_d = dec.op2_imm ? dec.imm     : i_regData2;

   // A load sitting in ID/EX cannot forward its data in time to the
   // instruction behind it, so that instruction waits one cycle.
   assign advance = !o_valid | i_ex_ready;
   assign hazard  = (HAZARD_EN != 0) & o_valid & o_MemRead & (o_rd != 5'd0) & i_valid &
                    ((dec.use1 & (o_rs1 == o_rd)) | (dec.use2 & (o_rs2 == o_rd)));
   assign o_ready = i_flush | (advance & !hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid     <= 1'b0;
         o_jal       <= 1'b0;
         o_jalr      <= 1'b0;
         o_branch    <= 1'b0;
         o_MemRead   <= 1'b0;
         o_MemWrite  <= 1'b0;
         o_RegWrite  <= 1'b0;
         o_illegal   <= 1'b0;
         o_Data_sel  <= '0;
         o_ALUop     <= '0;
         o_op1       <= '0;
         o_op2       <= '0;
         o_imm       <= '0;
         o_Rdata2    <= '0;
         o_pc        <= '0;
         o_rd        <= '0;
         o_func      <= '0;
         o_func3     <= '0;
         o_stall_cnt <= '0;
      end else if (i_flush || (advance && (hazard || !i_valid))) begin
         // Flush, bubble or empty slot: kill the control, keep stale data.
         o_valid    <= 1'b0;
         o_jal      <= 1'b0;
         o_jalr     <= 1'b0;
         o_branch   <= 1'b0;
         o_MemRead  <= 1'b0;
         o_MemWrite <= 1'b0;
         o_RegWrite <= 1'b0;
         o_illegal  <= 1'b0;
         o_Data_sel <= '0;
         o_ALUop    <= '0;
         if (!i_flush && hazard && (o_stall_cnt != {CNT_W{1'b1}}))
            o_stall_cnt <= o_stall_cnt + 1'b1;
      end else if (advance) begin
         o_valid    <= 1'b1;
         o_jal      <= dec.jal;
         o_jalr     <= dec.jalr;
         o_branch   <= dec.br;
         o_MemRead  <= dec.mr;
         o_MemWrite <= dec.mw;
         o_RegWrite <= dec.rw;
         o_illegal  <= dec.ill;
         o_Data_sel <= dec.dsel;
         o_ALUop    <= dec.alu;
         o_op1      <= op1_d;
         o_op2      <= op2_d;
         o_imm      <= dec.imm;
         o_Rdata2   <= i_regData2;
         o_pc       <= i_currentPC;
         o_rd       <= i_instruct[11:7];
         o_func     <= {i_instruct[30], i_instruct[14:12]};
         o_func3    <= i_instruct[14:12];
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe : scoreboard bench for id_stage_pipe.
// Three instances share one stimulus: [0] default, [1] HAZARD_EN=0,
// [2] CNT_W=2. The driver pushes hand-computed expectations for accepted
// instructions into exp_q; the monitor pops and compares on every EX handshake
// of instance [0]. Directed checks cover reset, stalls, backpressure and flush.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

   typedef struct {
      logic [31:0] pc, imm, op1, op2, rd2;
      logic [2:0]  alu;
      logic [1:0]  dsel;
      logic [6:0]  ctl;   // {ill, jal, jalr, br, mr, mw, rw}
      logic [4:0]  rd;
      logic [3:0]  func;
      logic        chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_flush, i_ex_ready;
   logic [31:0] i_instruct, i_currentPC, i_regData1, i_regData2;

   logic        rdy_v[3], vld_v[3], jal_v[3], jalr_v[3], br_v[3], mr_v[3], mw_v[3], rw_v[3], ill_v[3];
   logic [4:0]  rs1_v[3], rs2_v[3], rd_v[3];
   logic [1:0]  dsel_v[3];
   logic [2:0]  alu_v[3], f3_v[3];
   logic [3:0]  func_v[3];
   logic [31:0] op1_v[3], op2_v[3], imm_v[3], rdat_v[3], pc_v[3];
   logic [15:0] cnt_v[2];
   logic [1:0]  cnt2;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      id_stage_pipe #(.XLEN(32), .HAZARD_EN(g == 0 ? 1 : 0), .CNT_W(16)) dut (
         .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_v[g]), .i_instruct(i_instruct),
         .i_currentPC(i_currentPC), .o_rs1(rs1_v[g]), .o_rs2(rs2_v[g]), .i_regData1(i_regData1),
         .i_regData2(i_regData2), .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(vld_v[g]),
         .o_jal(jal_v[g]), .o_jalr(jalr_v[g]), .o_branch(br_v[g]), .o_MemRead(mr_v[g]),
         .o_MemWrite(mw_v[g]), .o_RegWrite(rw_v[g]), .o_Data_sel(dsel_v[g]), .o_ALUop(alu_v[g]),
         .o_op1(op1_v[g]), .o_op2(op2_v[g]), .o_imm(imm_v[g]), .o_Rdata2(rdat_v[g]), .o_pc(pc_v[g]),
         .o_rd(rd_v[g]), .o_func(func_v[g]), .o_func3(f3_v[g]), .o_illegal(ill_v[g]),
         .o_stall_cnt(cnt_v[g]));
   end

   id_stage_pipe #(.XLEN(32), .HAZARD_EN(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy_v[2]), .i_instruct(i_instruct),
      .i_currentPC(i_currentPC), .o_rs1(rs1_v[2]), .o_rs2(rs2_v[2]), .i_regData1(i_regData1),
      .i_regData2(i_regData2), .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(vld_v[2]),
      .o_jal(jal_v[2]), .o_jalr(jalr_v[2]), .o_branch(br_v[2]), .o_MemRead(mr_v[2]),
      .o_MemWrite(mw_v[2]), .o_RegWrite(rw_v[2]), .o_Data_sel(dsel_v[2]), .o_ALUop(alu_v[2]),
      .o_op1(op1_v[2]), .o_op2(op2_v[2]), .o_imm(imm_v[2]), .o_Rdata2(rdat_v[2]), .o_pc(pc_v[2]),
      .o_rd(rd_v[2]), .o_func(func_v[2]), .o_func3(f3_v[2]), .o_illegal(ill_v[2]),
      .o_stall_cnt(cnt2));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
      end
   endfunction

   function automatic exp_t mk(input logic [31:0] pc, imm, op1, op2, rd2, input logic [2:0] alu,
                               input logic [1:0] dsel, input logic [6:0] ctl, input logic [4:0] rd,
                               input logic [3:0] func, input logic chk_data);
      exp_t e;
      e.pc = pc; e.imm = imm; e.op1 = op1; e.op2 = op2; e.rd2 = rd2; e.alu = alu;
      e.dsel = dsel; e.ctl = ctl; e.rd = rd; e.func = func; e.chk_data = chk_data;
      return e;
   endfunction

   // Monitor: every EX handshake of instance 0 must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && vld_v[0] && i_ex_ready && !i_flush) begin
            if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("pc", pc_v[0], e.pc);
               chk("ctl", {25'd0, ill_v[0], jal_v[0], jalr_v[0], br_v[0], mr_v[0], mw_v[0], rw_v[0]},
                   {25'd0, e.ctl});
               chk("aluop", {29'd0, alu_v[0]}, {29'd0, e.alu});
               chk("dsel", {30'd0, dsel_v[0]}, {30'd0, e.dsel});
               chk("rd", {27'd0, rd_v[0]}, {27'd0, e.rd});
               chk("func", {28'd0, func_v[0]}, {28'd0, e.func});
               chk("func3", {29'd0, f3_v[0]}, {29'd0, e.func[2:0]});
               if (e.chk_data) begin
                  chk("imm", imm_v[0], e.imm);
                  chk("op1", op1_v[0], e.op1);
                  chk("op2", op2_v[0], e.op2);
                  chk("rdata2", rdat_v[0], e.rd2);
               end
            end
         end
      end
   end

   // Called at posedge+2. Presents an instruction until instance 0 takes it,
   // pushes its expectation, and returns at the posedge+2 after acceptance.
   task automatic send(input logic [31:0] ins, pc, r1, r2, input exp_t e, output int waits);
      bit done = 0;
      waits = 0;
      i_valid = 1'b1; i_instruct = ins; i_currentPC = pc; i_regData1 = r1; i_regData2 = r2;
      for (int k = 0; k < 20 && !done; k++) begin
         #2;
         if (rdy_v[0]) begin exp_q.push_back(e); done = 1; end
         else waits++;
         @(posedge clk); #2;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      i_valid = 1'b0;
   endtask

   localparam logic [31:0] I_ADDI1 = 32'h00500093, I_LW5 = 32'h00012283, I_ADD6 = 32'h00728333;
   localparam logic [31:0] I_LW0 = 32'h00012003, I_ADD0 = 32'h00700333, I_LUI = 32'h000282B7;
   localparam logic [31:0] I_JAL = 32'hFF9FF0EF, I_ADDI2 = 32'hFFF00113, I_SW = 32'h00312223;
   localparam logic [31:0] I_ILL = 32'h0000007F, I_BEQ = 32'hFE208EE3;

   initial begin
      exp_t e_addi1, e_lw5, e_add6, e_lw0, e_add0, e_lui, e_jal, e_addi2, e_sw, e_ill, e_beq, dummy;
      int w;
      e_addi1 = mk(32'h100, 32'd5, 32'd0, 32'd5, 32'h55, 3'b011, 2'b00, 7'b0000001, 5'd1, 4'h0, 1);
      e_lw5   = mk(32'h104, 32'd0, 32'h1000, 32'd0, 32'd0, 3'b000, 2'b01, 7'b0000101, 5'd5, 4'h2, 1);
      e_add6  = mk(32'h108, 32'd0, 32'h20, 32'h30, 32'h30, 3'b010, 2'b00, 7'b0000001, 5'd6, 4'h0, 1);
      e_lw0   = mk(32'h10C, 32'd0, 32'h2000, 32'd0, 32'd0, 3'b000, 2'b01, 7'b0000101, 5'd0, 4'h2, 1);
      e_add0  = mk(32'h110, 32'd0, 32'd0, 32'd7, 32'd7, 3'b010, 2'b00, 7'b0000001, 5'd6, 4'h0, 1);
      e_lui   = mk(32'h118, 32'h00028000, 32'hDEAD, 32'h00028000, 32'd0, 3'b100, 2'b11, 7'b0000001,
                   5'd5, 4'h0, 1);
      e_jal   = mk(32'h200, 32'hFFFFFFF8, 32'h200, 32'hFFFFFFF8, 32'd0, 3'b000, 2'b10, 7'b0100001,
                   5'd1, 4'hF, 1);
      e_addi2 = mk(32'h204, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 3'b011, 2'b00, 7'b0000001,
                   5'd2, 4'h8, 1);
      e_sw    = mk(32'h208, 32'd4, 32'h300, 32'd4, 32'hCAFE, 3'b000, 2'b00, 7'b0000010, 5'd4, 4'h2, 1);
      e_ill   = mk(32'h20C, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 2'b00, 7'b1000000, 5'd0, 4'h0, 0);
      e_beq   = mk(32'h210, 32'hFFFFFFFC, 32'h11, 32'h22, 32'h22, 3'b001, 2'b00, 7'b0001000,
                   5'd29, 4'h8, 1);

      rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
      i_instruct = '0; i_currentPC = '0; i_regData1 = '0; i_regData2 = '0;
      @(posedge clk); #2;
      chk("rst_valid", {31'd0, vld_v[0]}, 32'd0);
      chk("rst_regwrite", {31'd0, rw_v[0]}, 32'd0);
      chk("rst_imm", imm_v[0], 32'd0);
      chk("rst_pc", pc_v[0], 32'd0);
      chk("rst_cnt", {16'd0, cnt_v[0]}, 32'd0);
      chk("rst_ready", {31'd0, rdy_v[0]}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #2;

      // Stream, then a load-use pair.
      send(I_ADDI1, 32'h100, 32'd0, 32'h55, e_addi1, w);
      send(I_LW5, 32'h104, 32'h1000, 32'd0, e_lw5, w);
      i_valid = 1'b1; i_instruct = I_ADD6; i_currentPC = 32'h108; i_regData1 = 32'h20; i_regData2 = 32'h30;
      #2;
      chk("hazard_ready", {31'd0, rdy_v[0]}, 32'd0);
      chk("nohaz_ready", {31'd0, rdy_v[1]}, 32'd1);
      @(posedge clk); #2;
      chk("bubble_valid", {31'd0, vld_v[0]}, 32'd0);
      chk("nohaz_valid", {31'd0, vld_v[1]}, 32'd1);
      send(I_ADD6, 32'h108, 32'h20, 32'h30, e_add6, w);
      chk("after_bubble_wait", w, 32'd0);
      chk("stall_cnt1", {16'd0, cnt_v[0]}, 32'd1);

      // Four more load-use pairs: 5 bubbles total, 2-bit counter pins at 3.
      for (int n = 0; n < 4; n++) begin
         send(I_LW5, 32'h104, 32'h1000, 32'd0, e_lw5, w);
         send(I_ADD6, 32'h108, 32'h20, 32'h30, e_add6, w);
         chk("loaduse_wait", w, 32'd1);
      end
      chk("stall_cnt5", {16'd0, cnt_v[0]}, 32'd5);
      chk("stall_sat", {30'd0, cnt2}, 32'd3);
      chk("stall_nohaz", {16'd0, cnt_v[1]}, 32'd0);

      // Exemptions: load to x0, and LUI does not read rs1.
      send(I_LW0, 32'h10C, 32'h2000, 32'd0, e_lw0, w);
      send(I_ADD0, 32'h110, 32'd0, 32'd7, e_add0, w);
      chk("x0_no_stall", w, 32'd0);
      send(I_LW5, 32'h104, 32'h1000, 32'd0, e_lw5, w);
      send(I_LUI, 32'h118, 32'hDEAD, 32'd0, e_lui, w);
      chk("lui_no_stall", w, 32'd0);

      // Backpressure with jal held in ID/EX.
      send(I_JAL, 32'h200, 32'h77, 32'd0, e_jal, w);
      i_ex_ready = 1'b0;
      i_valid = 1'b1; i_instruct = I_ADDI2; i_currentPC = 32'h204; i_regData1 = '0; i_regData2 = '0;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("bp_valid", {31'd0, vld_v[0]}, 32'd1);
         chk("bp_ready", {31'd0, rdy_v[0]}, 32'd0);
         chk("bp_imm", imm_v[0], 32'hFFFFFFF8);
         chk("bp_op1", op1_v[0], 32'h200);
         chk("bp_dsel", {30'd0, dsel_v[0]}, 32'd2);
         @(posedge clk); #2;
      end
      i_ex_ready = 1'b1;
      send(I_ADDI2, 32'h204, 32'd0, 32'd0, e_addi2, w);

      // Flush with a store held in ID/EX and another in ID.
      send(I_SW, 32'h208, 32'h300, 32'hCAFE, e_sw, w);
      i_ex_ready = 1'b0;
      i_valid = 1'b1; i_flush = 1'b1; i_instruct = I_SW;
      #2;
      chk("flush_ready", {31'd0, rdy_v[0]}, 32'd1);
      @(posedge clk); #2;
      chk("flush_valid", {31'd0, vld_v[0]}, 32'd0);
      chk("flush_memwrite", {31'd0, mw_v[0]}, 32'd0);
      chk("flush_q_size", exp_q.size(), 32'd1);
      if (exp_q.size() != 0) dummy = exp_q.pop_front();
      i_flush = 1'b0; i_valid = 1'b0; i_ex_ready = 1'b1;

      send(I_ILL, 32'h20C, 32'd0, 32'd0, e_ill, w);
      send(I_BEQ, 32'h210, 32'h11, 32'h22, e_beq, w);

      // Reset in the middle of a load-use stall.
      send(I_LW5, 32'h104, 32'h1000, 32'd0, e_lw5, w);
      i_valid = 1'b1; i_instruct = I_ADD6; i_currentPC = 32'h108;
      #2;
      chk("pre_rst_stall", {31'd0, rdy_v[0]}, 32'd0);
      #3; rst = 1'b1; #1;
      chk("mid_rst_valid", {31'd0, vld_v[0]}, 32'd0);
      chk("mid_rst_memread", {31'd0, mr_v[0]}, 32'd0);
      chk("mid_rst_op1", op1_v[0], 32'd0);
      chk("mid_rst_cnt", {16'd0, cnt_v[0]}, 32'd0);
      chk("mid_rst_cnt_sat", {30'd0, cnt2}, 32'd0);
      i_valid = 1'b0;
      @(posedge clk); #2; rst = 1'b0;

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
